uart_tap: RTL and testbench
===========================

UART_TAP -- requirements
Module: uart_tap

Interface
REQ-001 The module SHALL have one clock, CLK_I, and a synchronous active-low reset, RST_NI, sampled on the rising edge of CLK_I.
REQ-002 The module SHALL have the following parameters:
- IDCODE, default 32'h0000_0001, value returned by the IDCODE command.
- TIMEOUT_CYCLES, default 1000, inter-byte receive timeout; 0 disables the timeout.
REQ-003 The module SHALL have the following ports:
- CLK_I in 1: clock.
- RST_NI in 1: synchronous active-low reset.
- RX_DATA_I in 8: received UART byte.
- RX_VALID_I in 1: RX_DATA_I is valid.
- RX_READY_O out 1: TAP accepts RX byte.
- TX_DATA_O out 8: byte to transmit.
- TX_VALID_O out 1: TX_DATA_O is valid.
- TX_READY_I in 1: transmitter accepts byte.
- DMI_O out 41: DMI request word {addr[6:0], data[31:0], op[1:0]}.
- DMI_WRITE_VALID_O out 1: DMI_O is offered to the DMI interface.
- DMI_WRITE_READY_I in 1: DMI interface has taken DMI_O.
- DMI_READ_READY_O out 1: TAP requests response / acknowledges completion.
- DMI_READ_VALID_I in 1: DMI_I is valid.
- DMI_I in 41: DMI response word {addr[6:0], data[31:0], err[1:0]}.
- DONE_I in 1: DMI interface has finished the DM transaction.
- DMI_HARD_RESET_O out 1: DMI hard-reset request.

Function
REQ-004 A transfer on any ready/valid pair SHALL occur in every cycle where both signals are 1 at the rising edge.
REQ-005 The state machine SHALL have these states: IDLE, RX_PAYLOAD, DMI_WRITE, WAIT_DONE, DMI_READ, TX_SEND, RESET_PULSE.
REQ-006 RX_READY_O SHALL be 1 only in IDLE and RX_PAYLOAD; bytes offered in any other state SHALL be left pending, not dropped.
REQ-007 In IDLE, each accepted byte SHALL be decoded as follows:
- 0x11 (DMI access): go to RX_PAYLOAD with byte count 0.
- 0x12 (IDCODE): load IDCODE into the TX buffer, length 4, go to TX_SEND.
- 0x13 (hard reset): go to RESET_PULSE.
- Any other value: ignore and stay in IDLE.
REQ-008 RX_PAYLOAD SHALL accept exactly 6 bytes, assembled little-endian into DMI_O[40:0]; bits [7:1] of byte 5 SHALL be ignored; after the 6th byte the state SHALL go to DMI_WRITE.
REQ-009 In RX_PAYLOAD, a cycle counter SHALL clear on every accepted byte.
REQ-010 If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES without a byte being accepted, the partial frame SHALL be discarded, DMI_O SHALL remain unchanged, and the state SHALL return to IDLE.
REQ-011 In DMI_WRITE, DMI_WRITE_VALID_O SHALL be 1 until the write transfer occurs, then the state SHALL go to WAIT_DONE; DMI_WRITE_VALID_O SHALL be 0 in every other state.
REQ-012 DMI_O SHALL hold its value from the write transfer until the next complete payload is received.
REQ-013 WAIT_DONE SHALL wait, with no cycle limit, for DONE_I=1, then go to DMI_READ.
REQ-014 DMI_READ_READY_O SHALL be 1 throughout DMI_READ and 0 in all other states.
REQ-015 On DMI_READ_VALID_I=1 in DMI_READ, the TAP SHALL capture DMI_I into the TX buffer with length 6 and go to TX_SEND.
REQ-016 If DMI_READ_VALID_I and DONE_I are both 1 in the same cycle, DMI_READ_VALID_I SHALL take precedence.
REQ-017 TX_SEND SHALL emit the buffer bytes LSB first; TX_VALID_O SHALL be 1 with stable TX_DATA_O until the transfer occurs.
REQ-018 For a 41-bit response, bits [7:1] of byte 5 SHALL be 0.
REQ-019 After the last byte transfers, TX_VALID_O SHALL drop in the next cycle and the state SHALL return to IDLE.
REQ-020 In RESET_PULSE, DMI_HARD_RESET_O SHALL be 1 for exactly one cycle; the TAP SHALL then send the single byte 0x13 via TX_SEND.
REQ-021 Command latency SHALL be:
- Byte accept to next-state output change: 1 cycle.
- 6th payload byte to DMI_WRITE_VALID_O=1: 1 cycle.

Reset
REQ-022 While RST_NI=0, the state SHALL be IDLE, and all outputs, counters, TX buffer and DMI_O SHALL be 0.
REQ-023 RST_NI=0 asserted mid-frame, mid-DMI-transaction or mid-transmit SHALL abort the operation within one cycle.
REQ-024 After such an abort, no stale byte or handshake SHALL be emitted after RST_NI returns to 1.

Verification
REQ-025 The bench SHALL cover the DMI access scenario: RX 0x11 then bytes 0x01,0x00,0x00,0x00,0x00,0x00 (op=1, addr=0) -> DMI_O=41'h1, DMI_WRITE_VALID_O until ready; DONE_I=1 -> DMI_READ_READY_O=1; DMI_I=41'h0_DEADBEEF<<2 -> TX bytes 0xBC,0xFB,0xB6,0x7A,0x03,0x00.
REQ-026 The bench SHALL cover the IDCODE scenario: RX 0x12 with IDCODE=32'h1234_5678 -> TX 0x78,0x56,0x34,0x12; TX_READY_I held 0 for 5 cycles -> TX_DATA_O stable at 0x78.
REQ-027 The bench SHALL cover the hard-reset scenario: RX 0x13 -> DMI_HARD_RESET_O=1 for exactly one cycle -> TX 0x13.
REQ-028 The bench SHALL cover the timeout scenario: RX 0x11, 0xAA, then idle for TIMEOUT_CYCLES=8 cycles -> state IDLE, DMI_WRITE_VALID_O never 1; the next byte 0x12 is decoded as IDCODE.
REQ-029 The bench SHALL cover the unknown/blocked scenario: RX 0x55 -> ignored with no TX; a byte offered during WAIT_DONE -> RX_READY_O=0, byte pending, and accepted after return to IDLE.
REQ-030 The bench SHALL cover the reset mid-operation scenario: RST_NI=0 for 1 cycle during TX_SEND byte 2 -> all outputs 0 next cycle, no further TX bytes.

Source files
------------

// File: rtl/uart_tap.sv
// rtl/uart_tap.sv - UART byte-stream debug TAP bridging host commands to a DMI request/response port
module uart_tap #(
    parameter logic [31:0] IDCODE         = 32'h0000_0001,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        CLK_I,
    input  logic        RST_NI,
    input  logic [7:0]  RX_DATA_I,
    input  logic        RX_VALID_I,
    output logic        RX_READY_O,
    output logic [7:0]  TX_DATA_O,
    output logic        TX_VALID_O,
    input  logic        TX_READY_I,
    output logic [40:0] DMI_O,
    output logic        DMI_WRITE_VALID_O,
    input  logic        DMI_WRITE_READY_I,
    output logic        DMI_READ_READY_O,
    input  logic        DMI_READ_VALID_I,
    input  logic [40:0] DMI_I,
    input  logic        DONE_I,
    output logic        DMI_HARD_RESET_O
);

    typedef enum logic [2:0] {
        IDLE, RX_PAYLOAD, DMI_WRITE, WAIT_DONE, DMI_READ, TX_SEND, RESET_PULSE
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;

    state_t      r_state;
    logic [2:0]  r_rx_cnt;
    logic [39:0] r_payload;
    logic [40:0] r_dmi;
    logic [31:0] r_timer;
    logic [47:0] r_tx_buf;
    logic [2:0]  r_tx_left;
    logic        r_rx_ready;
    logic        r_tx_valid;
    logic        r_dmi_wvalid;
    logic        r_dmi_rready;
    logic        r_hard_reset;

    logic w_rx_fire;
    logic w_tx_fire;

    assign w_rx_fire = RX_VALID_I & r_rx_ready;
    assign w_tx_fire = r_tx_valid & TX_READY_I;

    assign RX_READY_O        = r_rx_ready;
    assign TX_DATA_O         = r_tx_buf[7:0];
    assign TX_VALID_O        = r_tx_valid;
    assign DMI_O             = r_dmi;
    assign DMI_WRITE_VALID_O = r_dmi_wvalid;
    assign DMI_READ_READY_O  = r_dmi_rready;
    assign DMI_HARD_RESET_O  = r_hard_reset;

    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            r_state      <= IDLE;
            r_rx_cnt     <= 3'd0;
            r_payload    <= 40'd0;
            r_dmi        <= 41'd0;
            r_timer      <= 32'd0;
            r_tx_buf     <= 48'd0;
            r_tx_left    <= 3'd0;
            r_rx_ready   <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_dmi_wvalid <= 1'b0;
            r_dmi_rready <= 1'b0;
            r_hard_reset <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rx_ready <= 1'b1;
                    if (w_rx_fire) begin
                        case (RX_DATA_I)
                            8'h11: begin
                                r_state  <= RX_PAYLOAD;
                                r_rx_cnt <= 3'd0;
                                r_timer  <= 32'd0;
                            end
                            8'h12: begin
                                r_tx_buf   <= {16'd0, IDCODE};
                                r_tx_left  <= 3'd4;
                                r_tx_valid <= 1'b1;
                                r_rx_ready <= 1'b0;
                                r_state    <= TX_SEND;
                            end
                            8'h13: begin
                                r_hard_reset <= 1'b1;
                                r_rx_ready   <= 1'b0;
                                r_state      <= RESET_PULSE;
                            end
                            default: ;
                        endcase
                    end
                end
                RX_PAYLOAD: begin
                    if (w_rx_fire) begin
                        r_timer <= 32'd0;
                        // Bytes enter at the top so byte 0 ends up in the low bits
                        if (r_rx_cnt == 3'd5) begin
                            r_dmi        <= {RX_DATA_I[0], r_payload};
                            r_rx_ready   <= 1'b0;
                            r_dmi_wvalid <= 1'b1;
                            r_state      <= DMI_WRITE;
                        end else begin
                            r_payload <= {RX_DATA_I, r_payload[39:8]};
                            r_rx_cnt  <= r_rx_cnt + 3'd1;
                        end
                    end else if (TO_EN) begin
                        if (r_timer >= TO_LAST) begin
                            r_timer  <= 32'd0;
                            r_rx_cnt <= 3'd0;
                            r_state  <= IDLE;
                        end else begin
                            r_timer <= r_timer + 32'd1;
                        end
                    end
                end
                DMI_WRITE: begin
                    if (DMI_WRITE_READY_I) begin
                        r_dmi_wvalid <= 1'b0;
                        r_state      <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (DONE_I) begin
                        r_dmi_rready <= 1'b1;
                        r_state      <= DMI_READ;
                    end
                end
                DMI_READ: begin
                    if (DMI_READ_VALID_I) begin
                        r_tx_buf     <= {7'd0, DMI_I};
                        r_tx_left    <= 3'd6;
                        r_dmi_rready <= 1'b0;
                        r_tx_valid   <= 1'b1;
                        r_state      <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (w_tx_fire) begin
                        r_tx_buf  <= {8'd0, r_tx_buf[47:8]};
                        r_tx_left <= r_tx_left - 3'd1;
                        if (r_tx_left == 3'd1) begin
                            r_tx_valid <= 1'b0;
                            r_rx_ready <= 1'b1;
                            r_state    <= IDLE;
                        end
                    end
                end
                RESET_PULSE: begin
                    r_hard_reset <= 1'b0;
                    r_tx_buf     <= 48'h13;
                    r_tx_left    <= 3'd1;
                    r_tx_valid   <= 1'b1;
                    r_state      <= TX_SEND;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tap.sv
// tb/tb_uart_tap.sv - directed bench for uart_tap with a transfer-level scoreboard
module tb_uart_tap;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [40:0] dmi_o;
    logic        dmi_wvalid;
    logic        dmi_wready;
    logic        dmi_rready;
    logic        dmi_rvalid;
    logic [40:0] dmi_i;
    logic        done;
    logic        hard_reset;

    int n_cmp = 0;
    int n_bad = 0;
    int n_hr = 0;
    int n_wv = 0;

    logic [7:0]  exp_tx[$];
    logic [40:0] exp_dmi[$];
    logic [7:0]  tx_log[$];

    logic        prev_hold = 1'b0;
    logic        prev_rst = 1'b0;
    logic        prev_hr = 1'b0;
    logic [7:0]  prev_data = 8'd0;

    uart_tap #(.IDCODE(32'h1234_5678), .TIMEOUT_CYCLES(8)) dut (
        .CLK_I(clk), .RST_NI(rst_n),
        .RX_DATA_I(rx_data), .RX_VALID_I(rx_valid), .RX_READY_O(rx_ready),
        .TX_DATA_O(tx_data), .TX_VALID_O(tx_valid), .TX_READY_I(tx_ready),
        .DMI_O(dmi_o), .DMI_WRITE_VALID_O(dmi_wvalid), .DMI_WRITE_READY_I(dmi_wready),
        .DMI_READ_READY_O(dmi_rready), .DMI_READ_VALID_I(dmi_rvalid), .DMI_I(dmi_i),
        .DONE_I(done), .DMI_HARD_RESET_O(hard_reset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_tx(input logic [47:0] v, input int n);
        for (int i = 0; i < n; i++) exp_tx.push_back(v[8*i +: 8]);
    endtask

    function automatic logic [40:0] frame(input logic [47:0] bytes_le);
        logic [47:0] acc = 48'd0;
        for (int i = 0; i < 6; i++) acc = acc + (48'(bytes_le[8*i +: 8]) << (8*i));
        return acc[40:0];
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        rx_data = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rx_accept", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data = 8'd0;
    endtask

    task automatic drain_tx(input int budget);
        int k = 0;
        do begin
            @(posedge clk);
            k++;
        end while (exp_tx.size() != 0 && k < budget);
        chk("tx_drain_left", 64'(exp_tx.size()), 64'd0);
        exp_tx.delete();
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        chk({tag, "_tx_data"}, 64'(tx_data), 64'd0);
        chk({tag, "_dmi_o"}, 64'(dmi_o), 64'd0);
        chk({tag, "_dmi_wvalid"}, 64'(dmi_wvalid), 64'd0);
        chk({tag, "_dmi_rready"}, 64'(dmi_rready), 64'd0);
        chk({tag, "_hard_reset"}, 64'(hard_reset), 64'd0);
    endtask

    // Scoreboard: inputs settle 1 time unit after posedge, so negedge values predict the next edge
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL tx_unexpected: got 0x%0h, required no transfer", tx_data);
            end else begin
                chk("tx_byte", 64'(tx_data), 64'(exp_tx.pop_front()));
            end
            tx_log.push_back(tx_data);
        end
        if (prev_hold && prev_rst) begin
            chk("tx_hold_valid", 64'(tx_valid), 64'd1);
            chk("tx_hold_data", 64'(tx_data), 64'(prev_data));
        end
        if (rst_n && dmi_wvalid && dmi_wready) begin
            if (exp_dmi.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dmi_unexpected: got 0x%0h, required no write", dmi_o);
            end else begin
                chk("dmi_write", 64'(dmi_o), 64'(exp_dmi.pop_front()));
            end
        end
        if (dmi_wvalid) n_wv <= n_wv + 1;
        if (hard_reset) begin
            n_hr <= n_hr + 1;
            chk("hard_reset_width", 64'(prev_hr), 64'd0);
        end
        prev_hr   <= hard_reset;
        prev_hold <= tx_valid && !tx_ready;
        prev_data <= tx_data;
        prev_rst  <= rst_n;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [40:0] resp;
        logic [47:0] pay;
        int hr0;
        int wv0;
        int k;

        rst_n = 1'b0; rx_data = 8'd0; rx_valid = 1'b0; tx_ready = 1'b1;
        dmi_wready = 1'b0; dmi_rvalid = 1'b0; dmi_i = 41'd0; done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // DMI access, with a byte held pending during WAIT_DONE
        pay = 48'h00_00_00_00_00_01;
        exp_dmi.push_back(frame(pay));
        send_byte(8'h11);
        for (int i = 0; i < 6; i++) send_byte(pay[8*i +: 8]);
        @(negedge clk);
        chk("wvalid_latency", 64'(dmi_wvalid), 64'd1);
        chk("dmi_o_frame", 64'(dmi_o), 64'h1);
        chk("rx_ready_dmi_write", 64'(rx_ready), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("wvalid_held", 64'(dmi_wvalid), 64'd1);
        end
        @(posedge clk); #1; dmi_wready = 1'b1;
        @(posedge clk); #1; dmi_wready = 1'b0;
        @(negedge clk);
        chk("wvalid_drop", 64'(dmi_wvalid), 64'd0);
        chk("exp_dmi_used", 64'(exp_dmi.size()), 64'd0);
        rx_data = 8'h55;
        rx_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rx_blocked_wait_done", 64'(rx_ready), 64'd0);
            chk("rready_wait_done", 64'(dmi_rready), 64'd0);
        end
        @(posedge clk); #1; done = 1'b1;
        @(posedge clk); #1; done = 1'b0;
        @(negedge clk);
        chk("rready_dmi_read", 64'(dmi_rready), 64'd1);
        chk("dmi_o_hold", 64'(dmi_o), 64'h1);
        resp = 41'hDEAD_BEEF << 2;
        tx_log.delete();
        push_tx({7'd0, resp}, 6);
        @(posedge clk); #1;
        dmi_i = resp; dmi_rvalid = 1'b1; done = 1'b1;
        @(posedge clk); #1;
        dmi_i = 41'd0; dmi_rvalid = 1'b0; done = 1'b0;
        @(negedge clk);
        chk("rready_drop", 64'(dmi_rready), 64'd0);
        chk("tx_first_resp", 64'(tx_data), 64'hBC);
        drain_tx(50);
        @(negedge clk);
        chk("tx_valid_drop_resp", 64'(tx_valid), 64'd0);
        chk("resp_b0", 64'(tx_log[0]), 64'hBC);
        chk("resp_b1", 64'(tx_log[1]), 64'hFB);
        chk("resp_b2", 64'(tx_log[2]), 64'hB6);
        chk("resp_b3", 64'(tx_log[3]), 64'h7A);
        chk("resp_b4", 64'(tx_log[4]), 64'h03);
        chk("resp_b5", 64'(tx_log[5]), 64'h00);
        k = 0;
        while (!rx_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("pending_accepted", 64'(rx_ready), 64'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_data = 8'd0;
        repeat (6) begin
            @(negedge clk);
            chk("unknown_no_tx", 64'(tx_valid), 64'd0);
        end
        @(posedge clk); #1;

        // IDCODE with transmitter back-pressure
        tx_ready = 1'b0;
        tx_log.delete();
        push_tx({16'd0, 32'h1234_5678}, 4);
        send_byte(8'h12);
        repeat (5) begin
            @(negedge clk);
            chk("idcode_valid_stall", 64'(tx_valid), 64'd1);
            chk("idcode_data_stall", 64'(tx_data), 64'h78);
        end
        @(posedge clk); #1; tx_ready = 1'b1;
        drain_tx(50);
        @(negedge clk);
        chk("tx_valid_drop_id", 64'(tx_valid), 64'd0);
        chk("id_b0", 64'(tx_log[0]), 64'h78);
        chk("id_b1", 64'(tx_log[1]), 64'h56);
        chk("id_b2", 64'(tx_log[2]), 64'h34);
        chk("id_b3", 64'(tx_log[3]), 64'h12);
        @(posedge clk); #1;

        // Hard reset pulse followed by 0x13 echo
        hr0 = n_hr;
        tx_log.delete();
        push_tx(48'h13, 1);
        send_byte(8'h13);
        @(negedge clk);
        chk("hard_reset_high", 64'(hard_reset), 64'd1);
        chk("hr_no_tx_yet", 64'(tx_valid), 64'd0);
        @(negedge clk);
        chk("hard_reset_low", 64'(hard_reset), 64'd0);
        chk("hr_tx_valid", 64'(tx_valid), 64'd1);
        drain_tx(20);
        @(negedge clk);
        chk("hr_pulse_count", 64'(n_hr - hr0), 64'd1);
        chk("hr_echo", 64'(tx_log[0]), 64'h13);
        chk("tx_valid_drop_hr", 64'(tx_valid), 64'd0);
        @(posedge clk); #1;

        // Inter-byte timeout discards partial frame
        wv0 = n_wv;
        send_byte(8'h11);
        send_byte(8'hAA);
        repeat (8) @(posedge clk);
        #1;
        tx_log.delete();
        push_tx({16'd0, 32'h1234_5678}, 4);
        send_byte(8'h12);
        drain_tx(50);
        @(negedge clk);
        chk("timeout_no_write", 64'(n_wv - wv0), 64'd0);
        chk("timeout_dmi_o_kept", 64'(dmi_o), 64'h1);
        chk("timeout_then_id", 64'(tx_log[0]), 64'h78);
        @(posedge clk); #1;

        // Reset while the second IDCODE byte is pending
        tx_ready = 1'b0;
        push_tx(48'h78, 1);
        send_byte(8'h12);
        tx_ready = 1'b1;
        @(posedge clk); #1; tx_ready = 1'b0;
        @(negedge clk);
        chk("byte2_pending", 64'(tx_data), 64'h56);
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("abort");
        tx_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("abort_no_tx", 64'(tx_valid), 64'd0);
            chk("abort_no_wvalid", 64'(dmi_wvalid), 64'd0);
        end
        chk("abort_exp_left", 64'(exp_tx.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
